seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit seven-segment display. It holds a per-digit 4-bit display code and enable mask, cycles one digit at a time at a fixed slot rate, and emits the current digit's code for the segment decoder together with a one-hot digit select. New display content is double-buffered and committed only at frame boundaries, so mode/song indicators never tear mid-frame.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (≥2)
- TICK_DIV, 100000, clk cycles per digit slot (100 MHz → 1 kHz slot rate); ≥2
- BLINK_DIV, 125, frames per blink half-period (used only with SEG_BLINK_EN)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe: capture frame_in/en_in/blink_in into pending buffer
- frame_in  in  4*NUM_DIGITS  digit i code at [4i+3:4i]
- en_in  in  NUM_DIGITS  bit i = digit i lit
- blink_in  in  NUM_DIGITS  bit i = digit i blinks (ignored without SEG_BLINK_EN)
- seg_code  out  4  code of digit in current slot, to segment decoder
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when slot blanked
- frame_done  out  1  one-cycle pulse when slot NUM_DIGITS-1 ends
- load_pending  out  1  pending buffer holds uncommitted data

## Operation
- Prescaler cnt counts 0..TICK_DIV-1; tick when cnt==TICK_DIV-1, then cnt wraps to 0.
- Slot index slot counts 0..NUM_DIGITS-1, advances on tick, wraps NUM_DIGITS-1→0.
- Boundary = tick while slot==NUM_DIGITS-1. At boundary: frame_done=1 for that cycle; if load_pending, active registers ← pending, load_pending←0.
- load: pending ← inputs, load_pending←1. Repeated loads before boundary: last one wins.
- load on the boundary cycle: active ← frame_in/en_in/blink_in directly; load_pending←0 (no frame delay).
- Slot blanked when active en[slot]==0 (or blink-gated); blanked slot still occupies TICK_DIV cycles (uniform brightness); digit_sel=0, seg_code=active code unchanged.
- Codes passed through unmodified; decoding is downstream.

## Timing
- Reset values: cnt=0, slot=0, active/pending codes=0, enables=0, blink=0, load_pending=0, digit_sel=0, seg_code=0, frame_done=0, blink phase=0.
- digit_sel/seg_code registered; they reflect new slot on the same edge slot updates (1 cycle after tick cycle's inputs). Between updates they are stable.
- After rst deasserts: slot 0 outputs driven from cycle 1 with active data (all zero → dark) for TICK_DIV cycles.
- First committed load becomes visible at start of next slot 0, i.e. ≤ NUM_DIGITS*TICK_DIV cycles after load.
- load_pending rises the cycle after load; falls the cycle after boundary.
- rst mid-frame: all state returns to reset values next edge; pending data discarded.
- Frame period exactly NUM_DIGITS*TICK_DIV cycles; frame_done spacing identical.

## Configuration
- SEG_BLINK_EN defined: frame counter 0..BLINK_DIV-1 increments on frame_done, toggles blink phase on wrap; when phase=1 digits with active blink bit are blanked. Blink period = 2*BLINK_DIV frames.
- Undefined: no frame counter, no phase; blink_in and blink registers ignored/removed; behaviour identical to all blink bits 0.

## Structure
- Shared package seg_scan_pkg: NUM_DIGITS default, CODE_W=4, slot-index width function (clog2), default TICK_DIV/BLINK_DIV constants.
- One sub-module: scan_tick_gen (prescaler, parameter TICK_DIV, outputs 1-cycle tick, sync reset).
- Top holds slot counter, double buffer, blink logic, output registers.

## Test plan
- Reset then idle, TICK_DIV=4, NUM_DIGITS=8 → digit_sel=0, seg_code=0, frame_done pulses every 32 cycles.
- load codes 0..7, en=8'hFF mid-frame → no change until boundary; then digit_sel=8'h01 with seg_code=0, next slot 8'h02/1, …, 8'h80/7.
- en=8'b1010_1010 → slots 0,2,4,6 digit_sel=0 for 4 cycles each; odd slots lit.
- Two loads (A then B) in one frame → only B ever displayed; load exactly on boundary cycle → displayed from next slot 0, load_pending stays 0.
- rst asserted in slot 5 with pending set → next edge digit_sel=0, load_pending=0, slot restarts at 0.
- SEG_BLINK_EN, BLINK_DIV=2, blink=8'h01, en=8'hFF → digit 0 lit frames 0–1, dark frames 2–3, repeating; other digits always lit.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_scan_pkg;
   localparam int CODE_W         = 4;
   localparam int NUM_DIGITS_DEF = 8;
   localparam int TICK_DIV_DEF   = 100000;
   localparam int BLINK_DIV_DEF  = 125;

   // Counter width for a 0..n-1 range; never narrower than one bit.
   function automatic int slot_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/seg_scan_tick_gen.sv
// Slot-rate prescaler: tick is high for one cycle every TICK_DIV cycles.
module scan_tick_gen
   import seg_scan_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = slot_w(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan with frame-boundary double buffering.
// Optional blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int BLINK_DIV  = BLINK_DIV_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [CODE_W*NUM_DIGITS-1:0] frame_in,
   input  logic [NUM_DIGITS-1:0]        en_in,
   input  logic [NUM_DIGITS-1:0]        blink_in,
   output logic [CODE_W-1:0]            seg_code,
   output logic [NUM_DIGITS-1:0]        digit_sel,
   output logic                         frame_done,
   output logic                         load_pending
);
   localparam int SW = slot_w(NUM_DIGITS);

   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] codes_t;
   typedef struct packed {
      codes_t                code;
      logic [NUM_DIGITS-1:0] en;
`ifdef SEG_BLINK_EN
      logic [NUM_DIGITS-1:0] blink;
`endif
   } disp_t;

   logic                  tick, boundary, gate, lit;
   logic [SW-1:0]         slot, slot_nxt;
   disp_t                 act, pend, in_buf, act_nxt;
   logic [NUM_DIGITS-1:0] sel_nxt;

   scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign boundary   = tick && (slot == SW'(NUM_DIGITS - 1));
   assign frame_done = boundary;

   assign in_buf.code = frame_in;
   assign in_buf.en   = en_in;
`ifdef SEG_BLINK_EN
   assign in_buf.blink = blink_in;
`endif

   // A load landing on the boundary itself bypasses the pending buffer.
   always_comb begin
      act_nxt = act;
      if (boundary) begin
         if (load)              act_nxt = in_buf;
         else if (load_pending) act_nxt = pend;
      end
   end

   always_comb begin
      slot_nxt = slot;
      if (tick) slot_nxt = (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
   end

`ifdef SEG_BLINK_EN
   localparam int FW = slot_w(BLINK_DIV);

   logic [FW-1:0] fcnt, fcnt_nxt;
   logic          phase, phase_nxt;

   always_comb begin
      fcnt_nxt  = fcnt;
      phase_nxt = phase;
      if (boundary) begin
         if (fcnt == FW'(BLINK_DIV - 1)) begin
            fcnt_nxt  = '0;
            phase_nxt = ~phase;
         end else begin
            fcnt_nxt = fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt  <= '0;
         phase <= 1'b0;
      end else begin
         fcnt  <= fcnt_nxt;
         phase <= phase_nxt;
      end
   end

   assign gate = phase_nxt & act_nxt.blink[slot_nxt];
`else
   logic unused_blink;
   assign unused_blink = ^{blink_in, (BLINK_DIV != 0)};
   assign gate         = 1'b0;
`endif

   // Outputs are computed from next-state values so they switch on the slot edge.
   assign lit = act_nxt.en[slot_nxt] & ~gate;

   always_comb begin
      sel_nxt           = '0;
      sel_nxt[slot_nxt] = lit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot         <= '0;
         act          <= '0;
         pend         <= '0;
         load_pending <= 1'b0;
         seg_code     <= '0;
         digit_sel    <= '0;
      end else begin
         slot <= slot_nxt;
         act  <= act_nxt;
         if (load && !boundary) pend <= in_buf;
         if (boundary)  load_pending <= 1'b0;
         else if (load) load_pending <= 1'b1;
         seg_code  <= act_nxt.code[slot_nxt];
         digit_sel <= sel_nxt;
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4, NUM_DIGITS=8, BLINK_DIV=2.
module tb_seg_scan_ctrl;
   localparam int ND = 8;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [4*ND-1:0] frame_in = '0;
   logic [ND-1:0] en_in = '0;
   logic [ND-1:0] blink_in = '0;
   logic [3:0]    seg_code;
   logic [ND-1:0] digit_sel;
   logic          frame_done;
   logic          load_pending;

   int errors = 0;
   int checks = 0;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLINK_DIV(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .frame_in     (frame_in),
      .en_in        (en_in),
      .blink_in     (blink_in),
      .seg_code     (seg_code),
      .digit_sel    (digit_sel),
      .frame_done   (frame_done),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ends on the negedge of the boundary cycle (frame_done high).
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_done !== 1'b1 && n < 200);
      if (frame_done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL frame_done_timeout: frame_done=%b required 1 within 200 cycles", frame_done);
      end
   endtask

   // Ends on the first negedge of slot 0 of the next frame.
   task automatic sync_frame();
      wait_done();
      step(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int n, dark_bad;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (digit_sel !== 8'h00) begin errors++; $display("FAIL reset_sel: digit_sel=%h required 00", digit_sel); end
      checks++; if (seg_code !== 4'h0) begin errors++; $display("FAIL reset_code: seg_code=%h required 0", seg_code); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: frame_done=%b required 0", frame_done); end
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL reset_pend: load_pending=%b required 0", load_pending); end
      rst = 1'b0;
      n = 0; dark_bad = 0;
      while (frame_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (digit_sel !== 8'h00) dark_bad++;
      end
      checks++; if (n !== 31) begin errors++; $display("FAIL first_done: cycles=%0d required 31", n); end
      checks++; if (dark_bad !== 0) begin errors++; $display("FAIL idle_dark: lit cycles=%0d required 0", dark_bad); end
      step(1);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse: frame_done=%b required 0", frame_done); end
      n = 1;
      while (frame_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 32) begin errors++; $display("FAIL frame_period: cycles=%0d required 32", n); end
   endtask

   task automatic test_load();
      sync_frame();
      step(8);
      for (int i = 0; i < ND; i++) frame_in[4*i +: 4] = 4'(i);
      en_in = 8'hFF;
      load  = 1'b1;
      step(1);
      load = 1'b0;
      checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL pend_rise: load_pending=%b required 1", load_pending); end
      checks++; if (digit_sel !== 8'h00) begin errors++; $display("FAIL no_tear: digit_sel=%h required 00", digit_sel); end
      wait_done();
      checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL pend_hold: load_pending=%b required 1", load_pending); end
      step(1);
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL pend_fall: load_pending=%b required 0", load_pending); end
      for (int i = 0; i < ND; i++) begin
         checks++; if (digit_sel !== 8'(1 << i)) begin errors++; $display("FAIL scan_sel[%0d]: digit_sel=%h required %h", i, digit_sel, 8'(1 << i)); end
         checks++; if (seg_code !== 4'(i)) begin errors++; $display("FAIL scan_code[%0d]: seg_code=%h required %h", i, seg_code, 4'(i)); end
         step(3);
         checks++; if (digit_sel !== 8'(1 << i)) begin errors++; $display("FAIL scan_hold[%0d]: digit_sel=%h required %h", i, digit_sel, 8'(1 << i)); end
         step(1);
      end
   endtask

   task automatic test_en_mask();
      logic [ND-1:0] exp;
      for (int i = 0; i < ND; i++) frame_in[4*i +: 4] = 4'(15 - i);
      en_in = 8'b1010_1010;
      load  = 1'b1;
      step(1);
      load = 1'b0;
      sync_frame();
      for (int i = 0; i < ND; i++) begin
         exp = (i % 2 == 1) ? 8'(1 << i) : 8'h00;
         for (int c = 0; c < TD; c++) begin
            checks++; if (digit_sel !== exp) begin errors++; $display("FAIL mask_sel[%0d.%0d]: digit_sel=%h required %h", i, c, digit_sel, exp); end
            if (c == 0) begin
               checks++; if (seg_code !== 4'(15 - i)) begin errors++; $display("FAIL mask_code[%0d]: seg_code=%h required %h", i, seg_code, 4'(15 - i)); end
            end
            step(1);
         end
      end
   endtask

   task automatic test_last_wins();
      logic [ND-1:0] exp;
      frame_in = {ND{4'hA}}; en_in = 8'hFF; load = 1'b1;
      step(1); load = 1'b0;
      step(4);
      frame_in = {ND{4'h5}}; en_in = 8'h0F; load = 1'b1;
      step(1); load = 1'b0;
      sync_frame();
      for (int i = 0; i < ND; i++) begin
         exp = (i < 4) ? 8'(1 << i) : 8'h00;
         checks++; if (digit_sel !== exp) begin errors++; $display("FAIL last_sel[%0d]: digit_sel=%h required %h", i, digit_sel, exp); end
         checks++; if (seg_code !== 4'h5) begin errors++; $display("FAIL last_code[%0d]: seg_code=%h required 5", i, seg_code); end
         step(4);
      end
   endtask

   task automatic test_boundary_load();
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL bnd_pre: load_pending=%b required 0", load_pending); end
      wait_done();
      for (int i = 0; i < ND; i++) frame_in[4*i +: 4] = 4'(8 + i);
      en_in = 8'hFF;
      load  = 1'b1;
      step(1);
      load = 1'b0;
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL bnd_pend: load_pending=%b required 0", load_pending); end
      checks++; if (digit_sel !== 8'h01) begin errors++; $display("FAIL bnd_sel0: digit_sel=%h required 01", digit_sel); end
      checks++; if (seg_code !== 4'h8) begin errors++; $display("FAIL bnd_code0: seg_code=%h required 8", seg_code); end
      step(4);
      checks++; if (digit_sel !== 8'h02) begin errors++; $display("FAIL bnd_sel1: digit_sel=%h required 02", digit_sel); end
      checks++; if (seg_code !== 4'h9) begin errors++; $display("FAIL bnd_code1: seg_code=%h required 9", seg_code); end
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL bnd_pend_hold: load_pending=%b required 0", load_pending); end
   endtask

   task automatic test_rst_mid();
      int n, dark_bad;
      sync_frame();
      step(21);
      checks++; if (digit_sel !== 8'h20) begin errors++; $display("FAIL mid_sel: digit_sel=%h required 20", digit_sel); end
      frame_in = {ND{4'h3}}; en_in = 8'hFF; load = 1'b1;
      step(1); load = 1'b0;
      checks++; if (load_pending !== 1'b1) begin errors++; $display("FAIL mid_pend: load_pending=%b required 1", load_pending); end
      rst = 1'b1;
      step(1);
      checks++; if (digit_sel !== 8'h00) begin errors++; $display("FAIL rst_sel: digit_sel=%h required 00", digit_sel); end
      checks++; if (load_pending !== 1'b0) begin errors++; $display("FAIL rst_pend: load_pending=%b required 0", load_pending); end
      checks++; if (seg_code !== 4'h0) begin errors++; $display("FAIL rst_code: seg_code=%h required 0", seg_code); end
      rst = 1'b0;
      n = 0; dark_bad = 0;
      while (frame_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (digit_sel !== 8'h00) dark_bad++;
      end
      checks++; if (n !== 31) begin errors++; $display("FAIL rst_restart: cycles=%0d required 31", n); end
      step(1);
      for (int i = 0; i < ND; i++) begin
         if (digit_sel !== 8'h00) dark_bad++;
         step(4);
      end
      checks++; if (dark_bad !== 0) begin errors++; $display("FAIL rst_discard: lit samples=%0d required 0", dark_bad); end
   endtask

   task automatic test_blink();
      logic [ND-1:0] exp0;
      do_reset();
      for (int i = 0; i < ND; i++) frame_in[4*i +: 4] = 4'(i);
      en_in = 8'hFF; blink_in = 8'h01;
      step(4);
      load = 1'b1;
      step(1); load = 1'b0;
      for (int f = 1; f <= 5; f++) begin
         sync_frame();
`ifdef SEG_BLINK_EN
         exp0 = (f == 2 || f == 3) ? 8'h00 : 8'h01;
`else
         exp0 = 8'h01;
`endif
         checks++; if (digit_sel !== exp0) begin errors++; $display("FAIL blink_d0[f%0d]: digit_sel=%h required %h", f, digit_sel, exp0); end
         checks++; if (seg_code !== 4'h0) begin errors++; $display("FAIL blink_code[f%0d]: seg_code=%h required 0", f, seg_code); end
         step(4);
         checks++; if (digit_sel !== 8'h02) begin errors++; $display("FAIL blink_d1[f%0d]: digit_sel=%h required 02", f, digit_sel); end
      end
      blink_in = '0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_en_mask();
      test_last_wins();
      test_boundary_load();
      test_rst_mid();
      test_blink();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
